// File: rtl/i2s_mic_ctrl.sv
// i2s_mic_ctrl: bus master for a daisy chain of I2S microphones sharing one
// serial data line. Generates bclk_o and a one-period ws_o frame pulse, then
// shifts in NUM_MICS consecutive 32-bit words, tags each with its channel
// index and buffers it in a first-word-fall-through FIFO (valid/ready out).
//
// Handshake: a FIFO entry transfers on a rising clk_i edge where
// sample_valid_o && sample_ready_i; the head holds steady otherwise.
//
// Optional feature: define I2S_MIC_CTRL_FRAME_CNT_EN to add frame_cnt_o, a
// wrapping count of completed capture phases.
module i2s_mic_ctrl #(
    parameter int NUM_MICS   = 2,
    parameter int CLK_DIV    = 4,
    parameter int GAP_BCLKS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        lsb_first_i,
    input  logic        ovf_clr_i,
    input  logic        sd_i,
    output logic        bclk_o,
    output logic        ws_o,
    output logic [31:0] sample_data_o,
    output logic [2:0]  sample_ch_o,
    output logic        sample_valid_o,
    input  logic        sample_ready_i,
    output logic        overflow_o,
    output logic        busy_o,
    output logic [1:0]  state_dbg
`ifdef I2S_MIC_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_BCLKS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BCLKS - 1);
    localparam logic [2:0]       CH_LAST  = 3'(NUM_MICS - 1);

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic             fall;
    logic             lsb_q;
    logic [4:0]       bit_cnt;
    logic [2:0]       ch;
    logic [GAP_W-1:0] gap_cnt;
    logic [31:0]      word;
    logic [31:0]      word_next;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [34:0]      mem [FIFO_DEPTH];

    // A falling bclk edge is the tick on which bclk is currently high.
    assign fall      = (state != ST_IDLE) && (div_cnt == DIV_LAST) && bclk_o;
    assign state_dbg = state;

    // Bit clock divider; parked low with a cleared counter while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_cnt <= '0;
            bclk_o  <= 1'b0;
        end else if (state == ST_IDLE) begin
            div_cnt <= '0;
            bclk_o  <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk_o  <= ~bclk_o;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Next shift-register value with the current serial bit folded in.
    always_comb begin
        word_next = word;
        if (lsb_q) begin
            word_next = {sd_i, word[31:1]};
        end else begin
            word_next = {word[30:0], sd_i};
        end
    end

    assign push = (state == ST_CAPTURE) && fall && (bit_cnt == 5'd31);

    // Frame sequencer: START (ws pulse), CAPTURE (NUM_MICS words), GAP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            busy_o  <= 1'b0;
            ws_o    <= 1'b0;
            lsb_q   <= 1'b0;
            bit_cnt <= '0;
            ch      <= '0;
            gap_cnt <= '0;
            word    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_i) begin
                        lsb_q  <= lsb_first_i;
                        state  <= ST_START;
                        busy_o <= 1'b1;
                    end
                end
                ST_START: begin
                    // From IDLE the first fall raises ws; a fall with ws
                    // already high (also the GAP entry case) ends the pulse.
                    if (fall) begin
                        if (!ws_o) begin
                            ws_o <= 1'b1;
                        end else begin
                            ws_o    <= 1'b0;
                            state   <= ST_CAPTURE;
                            bit_cnt <= '0;
                            ch      <= '0;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (fall) begin
                        word <= word_next;
                        if (bit_cnt == 5'd31) begin
                            bit_cnt <= '0;
                            if (ch == CH_LAST) begin
                                state   <= ST_GAP;
                                gap_cnt <= '0;
                            end else begin
                                ch <= ch + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (fall) begin
                        if (gap_cnt == GAP_LAST) begin
                            if (en_i) begin
                                lsb_q <= lsb_first_i;
                                ws_o  <= 1'b1;
                                state <= ST_START;
                            end else begin
                                state  <= ST_IDLE;
                                busy_o <= 1'b0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign pop   = sample_valid_o && sample_ready_i;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign sample_valid_o               = (wr_ptr != rd_ptr);
    assign {sample_ch_o, sample_data_o} = mem[rd_ptr[AW-1:0]];

    // Output FIFO storage and pointers; a push into a full FIFO that is
    // popping in the same cycle reuses the slot the head just vacated.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= {ch, word_next};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end else if (ovf_clr_i) begin
            overflow_o <= 1'b0;
        end
    end

`ifdef I2S_MIC_CTRL_FRAME_CNT_EN
    // Completed capture phases, counted as CAPTURE hands over to GAP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_o <= '0;
        end else if (push && (ch == CH_LAST)) begin
            frame_cnt_o <= frame_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: doc/i2s_mic_ctrl.md
# i2s_mic_ctrl

- Bus-master controller for a daisy-chain of I2S microphones that share one serial data line.
- Generates `bclk_o` and the frame-start `ws_o` pulse, then captures `NUM_MICS` consecutive 32-bit words from `sd_i`, one per chained microphone.
- Tags each word with its channel index and buffers it in a small FIFO with a valid/ready output.
- Sits between the microphone chain and the sample consumer (DMA / scoreboard).

## Interface
- `NUM_MICS`, 2: microphones in the chain (1..8).
- `CLK_DIV`, 4: `clk_i` cycles per `bclk_o` half-period (≥2).
- `GAP_BCLKS`, 2: idle `bclk_o` periods between the end of capture and the next `ws_o` (≥1).
- `FIFO_DEPTH`, 4: output FIFO entries (power of 2, ≥2).
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `en_i`  in  1  run enable.
- `lsb_first_i`  in  1  bit order; sampled at frame start.
- `ovf_clr_i`  in  1  clears `overflow_o`.
- `sd_i`  in  1  shared serial data from the microphone chain.
- `bclk_o`  out  1  bit clock.
- `ws_o`  out  1  frame-start word select to the first microphone.
- `sample_data_o`  out  32  captured word.
- `sample_ch_o`  out  3  channel index (0 = first microphone).
- `sample_valid_o`  out  1  FIFO head valid.
- `sample_ready_i`  in  1  consumer accepts the head.
- `overflow_o`  out  1  sticky word-dropped flag.
- `busy_o`  out  1  FSM not in IDLE.

## Operation
- Reset values:
  - `bclk_o`=0, `ws_o`=0, `overflow_o`=0, `busy_o`=0, `sample_valid_o`=0.
  - `sample_data_o`=0, `sample_ch_o`=0.
  - FIFO empty, FSM in IDLE.
- `bclk_o` is a register toggled every `CLK_DIV` `clk_i` cycles while not in IDLE. In IDLE it is held at 0 and the divider counter is held at 0.
- FSM:
  - **IDLE**
    - On `en_i`=1: latch `lsb_first_i`, go to START.
  - **START**
    - `ws_o`=1 for exactly one `bclk_o` period, from one falling edge to the next. `ws_o` is driven on the `clk_i` edge that drives `bclk_o` 1→0.
    - Then go to CAPTURE with bit=0, ch=0.
  - **CAPTURE**
    - Sample `sd_i` on each `clk_i` edge that drives `bclk_o` 1→0.
    - Bit placement: MSB-first puts bit k of the stream at word[31-k]; LSB-first puts it at word[k].
    - After bit 31: push {ch, word} to the FIFO, then ch++ and bit=0.
    - After ch=`NUM_MICS`-1 completes: go to GAP.
  - **GAP**
    - Count `GAP_BCLKS` falling edges.
    - Then go to START if `en_i`=1, else IDLE.
- `en_i` deasserted mid-frame: the current frame completes and all `NUM_MICS` words are pushed; the FSM then goes to IDLE via GAP. `bclk_o` stops low.
- FIFO:
  - First-word-fall-through.
  - Pop when `sample_valid_o` && `sample_ready_i`.
  - Push when full with no same-cycle pop: the word is dropped, `overflow_o` is set, and the FIFO contents are unchanged.
  - Push when full with a same-cycle pop: the push is accepted.
  - Push and pop when empty: the word is written; valid rises next cycle.
- `overflow_o`: `ovf_clr_i` clears it. If a drop and a clear occur in the same cycle, the set wins.
- `sample_data_o` and `sample_ch_o` are stable while `sample_valid_o`=1 and `sample_ready_i`=0.

## Timing
- One frame = (1 + 32·`NUM_MICS` + `GAP_BCLKS`) `bclk_o` periods. Default: 67 periods = 536 `clk_i` cycles.
- First `bclk_o` rising edge: `CLK_DIV` cycles after leaving IDLE.
- `sample_valid_o`: rises 1 `clk_i` cycle after the edge that samples bit 31, when the FIFO was empty.
- `busy_o`: registered, =1 in START/CAPTURE/GAP.
- Reset mid-frame:
  - All outputs return to their reset values asynchronously.
  - A partial word is discarded.
  - FIFO is flushed.

## Configuration
- `I2S_MIC_CTRL_FRAME_CNT_EN` defined:
  - Adds output `frame_cnt_o` [15:0], reset 0.
  - Increments when the FSM leaves CAPTURE (all `NUM_MICS` words sampled); wraps 0xFFFF→0.
  - Not cleared by `en_i`.
- Not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- Defaults, MSB-first:
  - Stimulus: model mics return 0xA5A5_0F0F (ch0) and 0x1234_5678 (ch1); `sample_ready_i`=1.
  - Response: words pop in order {0,0xA5A50F0F}, {1,0x12345678}; `ws_o` high 8 `clk_i` cycles every 536.
- `lsb_first_i`=1:
  - Stimulus: same serial stream as above.
  - Response: bit-reversed words, 0xF0F0_A5A5 and 0x1E6A_2C48.
- Overflow:
  - Stimulus: `sample_ready_i`=0 for 3 frames (6 words).
  - Response: FIFO holds the first 4 words and `overflow_o`=1. Pulsing `ovf_clr_i` clears it; draining yields exactly the first 4 words.
- `en_i` dropped at bit 10 of ch0:
  - Response: both words of the frame are still delivered, then IDLE, with `bclk_o`=0 and `busy_o`=0.
- Async `rst_i` asserted mid-CAPTURE with 2 words buffered:
  - Response: `sample_valid_o`=0 immediately; no stale words after release.
- Frame counter (`I2S_MIC_CTRL_FRAME_CNT_EN` defined):
  - Stimulus: force `frame_cnt_o` to 0xFFFE, run 2 frames.
  - Response: reads 0xFFFF, then 0x0000.
